// File: rtl/reimu_life_ctrl_pkg.sv
// Shared types and default constants for the Reimu life/invulnerability controller.
// State encoding is fixed so the unused code 2'd3 can be recognised and recovered.
package reimu_life_ctrl_pkg;

    localparam int LIVES_W        = 3;
    localparam int TMR_W          = 8;
    localparam int DEF_INIT_LIVES = 3;
    localparam int DEF_INV_TICKS  = 32;

    typedef enum logic [1:0] {
        PLAY   = 2'd0,
        INVULN = 2'd1,
        OVER   = 2'd2
    } state_t;

    // Any hit source costs the same single life.
    function automatic logic hit_any(input logic shot_boss, input logic shot_enemy);
        return shot_boss | shot_enemy;
    endfunction

endpackage

// File: rtl/reimu_life_ctrl_inv_timer.sv
// Invulnerability down-counter: clear, load, saturating decrement and zero flag.
// Clear outranks load, load outranks decrement.
module reimu_life_ctrl_inv_timer
    import reimu_life_ctrl_pkg::*;
(
    input  logic             clk22,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    input  logic             dec,
    output logic [TMR_W-1:0] count,
    output logic             zero
);

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk22) begin
        if (rst || clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - TMR_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/reimu_life_ctrl.sv
// Player life controller: PLAY / INVULN / OVER with a one-life-per-hit guard window.
// Optional sprite blinking during invulnerability is enabled by defining REIMU_BLINK_EN.
module reimu_life_ctrl
    import reimu_life_ctrl_pkg::*;
#(
    parameter int INIT_LIVES  = DEF_INIT_LIVES,
    parameter int INV_TICKS   = DEF_INV_TICKS,
    parameter int BLINK_SHIFT = 1
) (
    input  logic               clk22,
    input  logic               rst,
    input  logic               shot_boss,
    input  logic               shot_enemy,
    input  logic               restart,
    output logic [LIVES_W-1:0] lives,
    output logic               invincible,
    output logic               reimu_visible,
    output logic               hit_pulse,
    output logic               game_over
);

    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(INIT_LIVES);
    localparam logic [TMR_W-1:0]   TICK_LOAD  = TMR_W'(INV_TICKS - 1);

    state_t             state, state_nx;
    logic [LIVES_W-1:0] lives_nx;
    logic               pulse_nx;
    logic               visible_nx;
    logic               hit;

    logic               tmr_clear, tmr_load, tmr_dec, tmr_zero;
    logic [TMR_W-1:0]   tmr_count;

    assign hit = hit_any(shot_boss, shot_enemy);

    reimu_life_ctrl_inv_timer inv_timer (
        .clk22    (clk22),
        .rst      (rst),
        .clear    (tmr_clear),
        .load     (tmr_load),
        .load_val (TICK_LOAD),
        .dec      (tmr_dec),
        .count    (tmr_count),
        .zero     (tmr_zero)
    );

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx  = state;
        lives_nx  = lives;
        pulse_nx  = 1'b0;
        tmr_clear = 1'b0;
        tmr_load  = 1'b0;
        tmr_dec   = 1'b0;

        if (restart) begin
            state_nx  = PLAY;
            lives_nx  = LIVES_INIT;
            tmr_clear = 1'b1;
        end else begin
            case (state)
                PLAY: begin
                    if (hit) begin
                        pulse_nx = 1'b1;
                        // Last life goes straight to OVER so lives never wraps.
                        if (lives > LIVES_W'(1)) begin
                            state_nx = INVULN;
                            lives_nx = lives - LIVES_W'(1);
                            tmr_load = 1'b1;
                        end else begin
                            state_nx = OVER;
                            lives_nx = '0;
                        end
                    end
                end
                INVULN: begin
                    if (tmr_zero) begin
                        state_nx = PLAY;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                OVER: begin
                    lives_nx = '0;
                end
                default: begin
                    state_nx = PLAY;
                end
            endcase
        end
    end

`ifdef REIMU_BLINK_EN
    // Blink phase follows the timer value the next cycle will hold.
    logic blink_bit;
    assign blink_bit = 1'((tmr_load ? TICK_LOAD : tmr_count - TMR_W'(1)) >> BLINK_SHIFT);
`else
    logic unused_blink;
    assign unused_blink = ^{tmr_count, TMR_W'(BLINK_SHIFT)};
`endif

    always_comb begin
        visible_nx = 1'b1;
        case (state_nx)
            INVULN: begin
`ifdef REIMU_BLINK_EN
                visible_nx = ~blink_bit;
`else
                visible_nx = 1'b1;
`endif
            end
            OVER:    visible_nx = 1'b0;
            default: visible_nx = 1'b1;
        endcase
    end

    always_ff @(posedge clk22) begin
        if (rst) begin
            state         <= PLAY;
            lives         <= LIVES_INIT;
            hit_pulse     <= 1'b0;
            invincible    <= 1'b0;
            game_over     <= 1'b0;
            reimu_visible <= 1'b1;
        end else begin
            state         <= state_nx;
            lives         <= lives_nx;
            hit_pulse     <= pulse_nx;
            invincible    <= (state_nx == INVULN);
            game_over     <= (state_nx == OVER);
            reimu_visible <= visible_nx;
        end
    end

endmodule

// File: tb/tb_reimu_life_ctrl.sv
// Directed self-checking bench for reimu_life_ctrl with default parameters.
// Blink expectations follow REIMU_BLINK_EN when it is defined for the build.
module tb_reimu_life_ctrl;

    logic       clk22 = 1'b0;
    logic       rst = 1'b1;
    logic       shot_boss = 1'b0;
    logic       shot_enemy = 1'b0;
    logic       restart = 1'b0;
    logic [2:0] lives;
    logic       invincible;
    logic       reimu_visible;
    logic       hit_pulse;
    logic       game_over;

    int tests_run    = 0;
    int tests_failed = 0;

    reimu_life_ctrl dut (
        .clk22         (clk22),
        .rst           (rst),
        .shot_boss     (shot_boss),
        .shot_enemy    (shot_enemy),
        .restart       (restart),
        .lives         (lives),
        .invincible    (invincible),
        .reimu_visible (reimu_visible),
        .hit_pulse     (hit_pulse),
        .game_over     (game_over)
    );

    always #5 clk22 = ~clk22;

    // One active edge, then settle on the falling edge for sampling and driving.
    task automatic tick();
        @(posedge clk22);
        @(negedge clk22);
    endtask

    task automatic do_reset();
        rst = 1'b1; shot_boss = 1'b0; shot_enemy = 1'b0; restart = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic exp_visible(input int k);
        int t;
        t = 31 - k;
`ifdef REIMU_BLINK_EN
        return ~t[1];
`else
        return (t >= 0);
`endif
    endfunction

    // Walks the rest of INVULN from observation k (timer = 31-k), checking blink and pulse.
    task automatic run_invuln(input int start_k, output int n, output int errs);
        int k;
        k = start_k;
        errs = 0;
        while (invincible && k < 100) begin
            if (reimu_visible !== exp_visible(k) || hit_pulse !== 1'b0) errs++;
            k++;
            tick();
        end
        n = k;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if ({lives, invincible, hit_pulse, game_over, reimu_visible} !== {3'd3, 4'b0001}) begin
            tests_failed++;
            $display("FAIL reset_state: got lives=%0d inv=%b pulse=%b over=%b vis=%b expected lives=3 inv=0 pulse=0 over=0 vis=1",
                     lives, invincible, hit_pulse, game_over, reimu_visible);
        end
    endtask

    task automatic test_single_hit();
        int n, errs;
        do_reset();
        shot_boss = 1'b1;
        tick();
        shot_boss = 1'b0;
        tests_run++;
        if ({lives, invincible, hit_pulse} !== {3'd2, 2'b11}) begin
            tests_failed++;
            $display("FAIL single_hit: got lives=%0d inv=%b pulse=%b expected lives=2 inv=1 pulse=1",
                     lives, invincible, hit_pulse);
        end
        tests_run++;
        if (reimu_visible !== exp_visible(0)) begin
            tests_failed++;
            $display("FAIL single_hit_vis: got %b expected %b", reimu_visible, exp_visible(0));
        end
        tick();
        tests_run++;
        if (hit_pulse !== 1'b0 || invincible !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_hit_pulse_width: got pulse=%b inv=%b expected pulse=0 inv=1",
                     hit_pulse, invincible);
        end
        run_invuln(1, n, errs);
        tests_run++;
        if (n !== 32) begin
            tests_failed++;
            $display("FAIL invuln_length: got %0d cycles expected 32", n);
        end
        tests_run++;
        if (errs !== 0) begin
            tests_failed++;
            $display("FAIL invuln_blink: got %0d bad cycles expected 0", errs);
        end
        // First PLAY cycle after INVULN must accept a hit.
        shot_enemy = 1'b1;
        tick();
        shot_enemy = 1'b0;
        tests_run++;
        if ({lives, invincible, hit_pulse} !== {3'd1, 2'b11}) begin
            tests_failed++;
            $display("FAIL hit_after_invuln: got lives=%0d inv=%b pulse=%b expected lives=1 inv=1 pulse=1",
                     lives, invincible, hit_pulse);
        end
    endtask

    task automatic test_held_hit();
        int pulses, n, errs;
        do_reset();
        pulses = 0;
        shot_boss = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (hit_pulse === 1'b1) pulses++;
        end
        shot_boss = 1'b0;
        tests_run++;
        if (pulses !== 1 || lives !== 3'd2) begin
            tests_failed++;
            $display("FAIL held_hit: got pulses=%0d lives=%0d expected pulses=1 lives=2", pulses, lives);
        end
        run_invuln(9, n, errs);
        tests_run++;
        if (n !== 32 || lives !== 3'd2) begin
            tests_failed++;
            $display("FAIL held_hit_invuln: got %0d cycles lives=%0d expected 32 cycles lives=2", n, lives);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        shot_boss = 1'b1; shot_enemy = 1'b1;
        tick();
        shot_boss = 1'b0; shot_enemy = 1'b0;
        tests_run++;
        if ({lives, hit_pulse} !== {3'd2, 1'b1}) begin
            tests_failed++;
            $display("FAIL simultaneous_hit: got lives=%0d pulse=%b expected lives=2 pulse=1", lives, hit_pulse);
        end
        tick();
        tests_run++;
        if ({lives, hit_pulse} !== {3'd2, 1'b0}) begin
            tests_failed++;
            $display("FAIL simultaneous_single_pulse: got lives=%0d pulse=%b expected lives=2 pulse=0", lives, hit_pulse);
        end
    endtask

    task automatic test_game_over();
        int n, errs, bad;
        do_reset();
        for (int h = 0; h < 2; h++) begin
            shot_enemy = 1'b1;
            tick();
            shot_enemy = 1'b0;
            run_invuln(0, n, errs);
        end
        shot_boss = 1'b1;
        tick();
        shot_boss = 1'b0;
        tests_run++;
        if ({lives, game_over, reimu_visible, invincible, hit_pulse} !== {3'd0, 4'b1001}) begin
            tests_failed++;
            $display("FAIL game_over_entry: got lives=%0d over=%b vis=%b inv=%b pulse=%b expected lives=0 over=1 vis=0 inv=0 pulse=1",
                     lives, game_over, reimu_visible, invincible, hit_pulse);
        end
        bad = 0;
        shot_boss = 1'b1; shot_enemy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if ({lives, game_over, hit_pulse, reimu_visible} !== {3'd0, 3'b100}) bad++;
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL game_over_hold: got %0d bad cycles expected 0", bad);
        end
        // Restart wins over the hit still being driven.
        restart = 1'b1;
        tick();
        restart = 1'b0; shot_boss = 1'b0; shot_enemy = 1'b0;
        tests_run++;
        if ({lives, game_over, invincible, hit_pulse, reimu_visible} !== {3'd3, 4'b0001}) begin
            tests_failed++;
            $display("FAIL restart_from_over: got lives=%0d over=%b inv=%b pulse=%b vis=%b expected lives=3 over=0 inv=0 pulse=0 vis=1",
                     lives, game_over, invincible, hit_pulse, reimu_visible);
        end
        restart = 1'b1; shot_boss = 1'b1;
        tick();
        restart = 1'b0; shot_boss = 1'b0;
        tests_run++;
        if ({lives, invincible, hit_pulse} !== {3'd3, 2'b00}) begin
            tests_failed++;
            $display("FAIL restart_over_hit: got lives=%0d inv=%b pulse=%b expected lives=3 inv=0 pulse=0",
                     lives, invincible, hit_pulse);
        end
    endtask

    task automatic test_rst_mid_invuln();
        do_reset();
        shot_boss = 1'b1;
        tick();
        shot_boss = 1'b0;
        repeat (4) tick();
        tests_run++;
        if (invincible !== 1'b1 || lives !== 3'd2) begin
            tests_failed++;
            $display("FAIL rst_setup: got inv=%b lives=%0d expected inv=1 lives=2", invincible, lives);
        end
        rst = 1'b1; restart = 1'b1; shot_enemy = 1'b1;
        tick();
        rst = 1'b0; restart = 1'b0; shot_enemy = 1'b0;
        tests_run++;
        if ({lives, invincible, hit_pulse, game_over, reimu_visible} !== {3'd3, 4'b0001}) begin
            tests_failed++;
            $display("FAIL rst_mid_invuln: got lives=%0d inv=%b pulse=%b over=%b vis=%b expected lives=3 inv=0 pulse=0 over=0 vis=1",
                     lives, invincible, hit_pulse, game_over, reimu_visible);
        end
        tick();
        tests_run++;
        if ({lives, invincible, hit_pulse} !== {3'd3, 2'b00}) begin
            tests_failed++;
            $display("FAIL rst_then_play: got lives=%0d inv=%b pulse=%b expected lives=3 inv=0 pulse=0",
                     lives, invincible, hit_pulse);
        end
    endtask

    initial begin
        @(negedge clk22);
        test_reset();
        test_single_hit();
        test_held_hit();
        test_simultaneous();
        test_game_over();
        test_rst_mid_invuln();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
